// File: rtl/fifo_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_pkg
// Shared definitions for the read-side FIFO stream reader:
//   - default FIFO word / beat widths, also used where the FIFO is instantiated
//   - control state encoding (holding register empty / sending)
//   - constant clog2 helper for sizing the beat index
// -----------------------------------------------------------------------------
package fifo_rd_pkg;

  // Default widths shared with the dual-clock FIFO instantiation.
  localparam int FIFO_RD_WD_DEFAULT = 256;
  localparam int FIFO_RD_WO_DEFAULT = 32;

  // Holding register state: EMPTY means no word held, SEND means beats pending.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SEND  = 1'b1
  } rd_state_e;

  // Ceiling log2 for elaboration-time sizing (value >= 2 expected).
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((32'sd1 <<< res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage : fifo_rd_pkg

// File: rtl/fifo_stream_reader_beat_mux.sv
// -----------------------------------------------------------------------------
// beat_mux
// Combinational selection of one WO-bit beat out of the WD-bit held word.
//
// Build option: FIFO_RD_MSB_FIRST_EN
//   undefined : beat 0 is the least significant slice (default)
//   defined   : beat 0 is the most significant slice
//
// Ports:
//   data_i   in  WD  word held by the reader
//   beat_i   in  WB  current beat index (0 .. NB-1)
//   slice_o  out WO  selected beat payload
// -----------------------------------------------------------------------------
module beat_mux
  import fifo_rd_pkg::*;
#(
  parameter int WD = FIFO_RD_WD_DEFAULT,
  parameter int WO = FIFO_RD_WO_DEFAULT,
  localparam int NB = WD / WO,
  localparam int WB = clog2(NB)
) (
  input  logic [WD-1:0] data_i,
  input  logic [WB-1:0] beat_i,
  output logic [WO-1:0] slice_o
);

  logic [WO-1:0] slices_s [NB];
  logic [WB-1:0] idx_s;

  // Split the word into its NB slices, slice g holding bits [g*WO +: WO].
  for (genvar g = 0; g < NB; g++) begin : g_slice
    assign slices_s[g] = data_i[g*WO +: WO];
  end

`ifdef FIFO_RD_MSB_FIRST_EN
  // Beat 0 maps to the top slice, so the index counts down.
  assign idx_s = WB'(NB - 1) - beat_i;
`else
  // Beat 0 maps to the bottom slice.
  assign idx_s = beat_i;
`endif

  assign slice_o = slices_s[idx_s];

endmodule : beat_mux

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
// Read-domain consumer for a first-word-fall-through FIFO. Pops WD-bit words
// into a holding register and serialises each as NB = WD/WO beats on a
// valid/ready stream. The next word is popped on the same edge that accepts
// the final beat, so back-to-back words flow without a bubble.
//
// Build option: FIFO_RD_MSB_FIRST_EN (beat order, see beat_mux).
//
// Ports:
//   rd_clk      in  1   read clock, rising edge
//   rst_n       in  1   asynchronous active-low reset
//   fifo_dout   in  WD  FIFO head word, valid while fifo_empty is low
//   fifo_empty  in  1   FIFO empty flag
//   fifo_rd_en  out 1   combinational pop strobe
//   flush       in  1   discard the held word this cycle
//   out_valid   out 1   beat available
//   out_ready   in  1   downstream accept
//   out_data    out WO  beat payload
//   out_last    out 1   final beat of the word
//   out_beat    out WB  current beat index
//   busy        out 1   holding register occupied (same as out_valid)
// -----------------------------------------------------------------------------
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int WD = FIFO_RD_WD_DEFAULT,
  parameter int WO = FIFO_RD_WO_DEFAULT,
  localparam int NB = WD / WO,
  localparam int WB = clog2(NB)
) (
  input  logic          rd_clk,
  input  logic          rst_n,
  input  logic [WD-1:0] fifo_dout,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WO-1:0] out_data,
  output logic          out_last,
  output logic [WB-1:0] out_beat,
  output logic          busy
);

  rd_state_e     state_q, state_d;
  logic [WD-1:0] hold_q, hold_d;
  logic [WB-1:0] beat_q, beat_d;

  logic hold_vld_s;
  logic last_beat_s;
  logic accept_s;
  logic pop_s;

  assign hold_vld_s  = (state_q == ST_SEND);
  assign last_beat_s = (beat_q == WB'(NB - 1));
  assign accept_s    = hold_vld_s & out_ready;

  // Pop when empty-handed, or when the last beat leaves this edge (zero-bubble
  // reload). rst_n gates the strobe so no pop is issued while in reset.
  assign pop_s = rst_n & ~fifo_empty & ~flush
               & (~hold_vld_s | (accept_s & last_beat_s));

  // Next-state logic: flush dominates a pop, a pop dominates a plain advance.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    beat_d  = beat_q;
    if (flush) begin
      state_d = ST_EMPTY;
      beat_d  = {WB{1'b0}};
    end else if (pop_s) begin
      state_d = ST_SEND;
      hold_d  = fifo_dout;
      beat_d  = {WB{1'b0}};
    end else begin
      case (state_q)
        ST_SEND: begin
          if (accept_s && !last_beat_s) begin
            beat_d = beat_q + WB'(1);
          end else if (accept_s) begin
            // Final beat taken with nothing to reload; beat index stays put
            // until the next pop restarts it.
            state_d = ST_EMPTY;
          end else begin
            beat_d = beat_q;
          end
        end
        ST_EMPTY: begin
          state_d = ST_EMPTY;
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State, holding register and beat counter.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      hold_q  <= {WD{1'b0}};
      beat_q  <= {WB{1'b0}};
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      beat_q  <= beat_d;
    end
  end

  beat_mux #(
    .WD (WD),
    .WO (WO)
  ) u_beat_mux (
    .data_i  (hold_q),
    .beat_i  (beat_q),
    .slice_o (out_data)
  );

  assign fifo_rd_en = pop_s;
  assign out_valid  = hold_vld_s;
  assign busy       = hold_vld_s;
  assign out_last   = hold_vld_s & last_beat_s;
  assign out_beat   = beat_q;

endmodule : fifo_stream_reader

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
// Self-checking bench for fifo_stream_reader with WD=64, WO=16 (NB=4).
// The reference model keeps the held word as a queue of remaining beats and
// the FIFO as a queue of words; expectations come from those queues.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

  localparam int WD = 64;
  localparam int WO = 16;
  localparam int NB = 4;
  localparam int WB = 2;

  logic          rd_clk;
  logic          rst_n;
  logic [WD-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [WO-1:0] out_data;
  logic          out_last;
  logic [WB-1:0] out_beat;
  logic          busy;

  fifo_stream_reader #(.WD(WD), .WO(WO)) dut (
    .rd_clk     (rd_clk),
    .rst_n      (rst_n),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_beat   (out_beat),
    .busy       (busy)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;

  logic [WD-1:0] fifoq [$];  // words waiting in the FIFO
  logic [WO-1:0] cur   [$];  // beats of the held word still to be sent
  logic [WO-1:0] got   [$];  // beats accepted downstream

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the FIFO read port from the word queue (junk on dout when empty).
  task automatic drive_fifo();
    fifo_empty = (fifoq.size() == 0);
    if (fifoq.size() != 0) fifo_dout = fifoq[0];
    else                   fifo_dout = {$urandom, $urandom};
  endtask

  task automatic push(input logic [WD-1:0] w);
    fifoq.push_back(w);
    drive_fifo();
  endtask

  // Split a word into its beats in transmission order.
  task automatic load(input logic [WD-1:0] w);
    cur.delete();
    for (int i = 0; i < NB; i++) begin
`ifdef FIFO_RD_MSB_FIRST_EN
      cur.push_back(w[(NB-1-i)*WO +: WO]);
`else
      cur.push_back(w[i*WO +: WO]);
`endif
    end
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic cycle();
    logic ep, acc, fl;
    #1;
    ep = !fifo_empty && !flush &&
         (cur.size() == 0 || (out_ready && cur.size() == 1));
    acc = (cur.size() != 0) && out_ready;
    fl  = flush;
    chk("valid", 64'(out_valid),  64'(cur.size() != 0));
    chk("busy",  64'(busy),       64'(cur.size() != 0));
    chk("last",  64'(out_last),   64'(cur.size() == 1));
    chk("rd_en", 64'(fifo_rd_en), 64'(ep));
    if (cur.size() != 0) begin
      chk("data", 64'(out_data), 64'(cur[0]));
      chk("beat", 64'(out_beat), 64'(NB - cur.size()));
    end
    if (fifo_rd_en) n_pops++;
    if (acc) got.push_back(out_data);
    @(posedge rd_clk);
    if (fl) cur.delete();
    else if (ep) load(fifoq.pop_front());
    else if (acc) void'(cur.pop_front());
    #1;
    drive_fifo();
    @(negedge rd_clk);
  endtask

  // Run until the model's held word is at the given beat (bounded).
  task automatic run_to_beat(input int b);
    int guard;
    guard = 0;
    while (!(cur.size() == NB - b) && guard < 50) begin
      cycle();
      guard++;
    end
    chk("reach_beat", 64'(cur.size()), 64'(NB - b));
  endtask

  logic [WO-1:0] exp_seq [4];

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive_fifo();
    #2;
    chk("rst_valid", 64'(out_valid),  64'd0);
    chk("rst_data",  64'(out_data),   64'd0);
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    @(negedge rd_clk);
    rst_n = 1'b1;

    // Single word, ready held high.
`ifdef FIFO_RD_MSB_FIRST_EN
    exp_seq = '{16'h4444, 16'h3333, 16'h2222, 16'h1111};
`else
    exp_seq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
`endif
    got.delete();
    n_pops = 0;
    push(64'h4444_3333_2222_1111);
    for (int i = 0; i < 7; i++) cycle();
    chk("single_pops", 64'(n_pops), 64'd1);
    chk("single_cnt",  64'(got.size()), 64'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("single_seq", 64'(got[i]), 64'(exp_seq[i]));

    // Two queued words, no gaps.
    n_pops = 0;
    got.delete();
    push(64'h8888_7777_6666_5555);
    push(64'hDDDD_CCCC_BBBB_AAAA);
    for (int i = 0; i < 11; i++) cycle();
    chk("two_pops", 64'(n_pops), 64'd2);
    chk("two_cnt",  64'(got.size()), 64'd8);

    // Backpressure at beat 2 for five cycles with another word queued.
    push(64'h4444_3333_2222_1111);
    push(64'h0123_4567_89AB_CDEF);
    run_to_beat(2);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();

    // Flush at beat 1 with the FIFO non-empty.
    push(64'h1234_5678_9ABC_DEF0);
    push(64'hFEDC_BA98_7654_3210);
    run_to_beat(1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    for (int i = 0; i < 8; i++) cycle();

    // Asynchronous reset at beat 2.
    push(64'h4444_3333_2222_1111);
    push(64'h5A5A_A5A5_0F0F_F0F0);
    run_to_beat(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid),  64'd0);
    chk("arst_busy",  64'(busy),       64'd0);
    chk("arst_last",  64'(out_last),   64'd0);
    chk("arst_data",  64'(out_data),   64'd0);
    chk("arst_beat",  64'(out_beat),   64'd0);
    chk("arst_rd_en", 64'(fifo_rd_en), 64'd0);
    cur.delete();
    @(posedge rd_clk);
    @(negedge rd_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cycle();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) == 0 && fifoq.size() < 4) push({$urandom, $urandom});
      cycle();
    end
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fifo_stream_reader

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side consumer for the team's dual-clock FIFO. Sits entirely in the read clock domain.
- Pops WD-bit words from a first-word-fall-through FIFO read port.
- Serializes each word into WD/WO narrower beats on a valid/ready output stream, flagging the last beat of each word.
- Hides FIFO pop timing from downstream logic, with zero-bubble back-to-back word delivery.

Parameters:
- WD, 256, FIFO word width in bits.
- WO, 32, output beat width in bits. WD must be an integer multiple of WO; WD/WO >= 2.
- NB, WD/WO (derived localparam), beats per FIFO word.
- WB, clog2(NB) (derived localparam), beat-index width.

Ports:
- rd_clk  in  1  read-domain clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fifo_dout  in  WD  FIFO head word; valid whenever fifo_empty=0 (fall-through).
- fifo_empty  in  1  FIFO empty flag, rd_clk domain.
- fifo_rd_en  out  1  pop strobe, combinational; head advances at this edge.
- flush  in  1  synchronous discard of the word currently held.
- out_valid  out  1  beat available.
- out_ready  in  1  downstream accept.
- out_data  out  WO  beat payload.
- out_last  out  1  high on beat NB-1 of each word.
- out_beat  out  WB  index of the current beat.
- busy  out  1  holding register occupied (equals out_valid).

Behaviour:
- Storage: holding register hold_q[WD-1:0], flag hold_vld, beat counter beat_q[WB-1:0].
- Two states:
  - EMPTY: hold_vld=0.
  - SEND: hold_vld=1.
- Pop rule (combinational): fifo_rd_en = rst_n & ~fifo_empty & ~flush & (~hold_vld | (out_valid & out_ready & beat_q==NB-1)).
- On fifo_rd_en: hold_q<=fifo_dout, hold_vld<=1, beat_q<=0.
  - Latency: FIFO non-empty at cycle t -> out_valid=1 at t+1.
- SEND, accept (out_valid & out_ready):
  - beat_q<NB-1: beat_q<=beat_q+1.
  - beat_q==NB-1 with FIFO non-empty: reload, no bubble.
  - beat_q==NB-1 with FIFO empty: hold_vld<=0, go to EMPTY.
- SEND, no accept: out_valid, out_data, out_last and out_beat are held stable, never withdrawn.
- out_data = hold_q[beat_q*WO +: WO]; beat 0 is the LSB slice.
- out_last = hold_vld & (beat_q==NB-1).
- out_beat = beat_q. beat_q wraps NB-1 -> 0 only on reload; it never increments past NB-1.
- flush=1:
  - hold_vld<=0, beat_q<=0, no pop that cycle. Flush dominates accept and reload.
  - out_valid remains visible during the flush cycle; an accept in that cycle is still counted by downstream, but no state advances.
- fifo_empty asserting mid-word: no effect until the word completes.
- Reset (rst_n low, any time, including mid-word):
  - hold_vld=0, beat_q=0, hold_q=0, out_valid=0, out_last=0, out_data=0, out_beat=0, busy=0, fifo_rd_en=0.
  - A partially sent word is lost.
  - First pop possible on the first edge after rst_n deasserts.
- Only one pop per cycle, ever.
- No pop while the holding register is occupied, except at the final accepted beat.

Optional Feature:
- Macro FIFO_RD_MSB_FIRST_EN.
- Defined: beat 0 is the MSB slice, out_data = hold_q[(NB-1-beat_q)*WO +: WO]. Handshake, out_last and out_beat are unchanged.
- Undefined: LSB-first order as above.

Decomposition:
- Shared package fifo_rd_pkg:
  - localparam function for clog2.
  - state encoding typedef (ST_EMPTY=1'b0, ST_SEND=1'b1).
  - default WD/WO constants shared with the FIFO instantiation.
- One natural sub-module, beat_mux: combinational WO slice select from hold_q by beat index, with the FIFO_RD_MSB_FIRST_EN ordering switch inside it.
- Control FSM and counter stay in the top.

Test Plan (bench uses WD=64, WO=16, NB=4):
- Single word 0x4444_3333_2222_1111, out_ready=1 -> out_data 0x1111, 0x2222, 0x3333, 0x4444 on 4 consecutive cycles; out_last only on 0x4444; exactly one fifo_rd_en pulse; out_valid first high the cycle after the pop.
- Two words queued, out_ready=1 -> 8 consecutive beats with no out_valid gap; second fifo_rd_en coincides with the accept of beat 3.
- Backpressure: out_ready low for 5 cycles at beat 2 -> out_data=0x3333 and out_beat=2 held stable throughout; no fifo_rd_en while held.
- flush asserted at beat 1 with FIFO non-empty -> next cycle out_valid=0; following cycle pops the next word and restarts at beat 0.
- rst_n pulsed low at beat 2 -> all outputs 0 immediately (asynchronous); after release the next FIFO word starts at beat 0.
- With FIFO_RD_MSB_FIRST_EN defined, word 0x4444_3333_2222_1111 -> beats 0x4444, 0x3333, 0x2222, 0x1111; out_last on 0x1111.
